seq_div: RTL and testbench

//  Iterative radix-2 restoring divider; inverse of the combinational 28x28 multiplier.

---
 rtl/seq_div.sv | 211 +++++++++++++++++++++
 tb/tb_seq_div.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// seq_div: iterative radix-2 restoring divider, one quotient bit per clock.
// Inverse of the 28x28 multiplier; normalises r_ii in the QR stage.
// Optional build macro: SEQ_DIV_SIGNED_EN (two's-complement operands,
// truncate-toward-zero; sign fix applied on DONE, latency unchanged).
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   start_i      request, sampled only in IDLE
//   dividend_i   numerator (DIVIDEND_W), captured on accept
//   divisor_i    denominator (DIVISOR_W), captured on accept
//   busy_o       high from the cycle after accept through the done cycle
//   done_o       one-cycle pulse, results valid
//   quotient_o   quotient (DIVIDEND_W), held until the next result
//   remainder_o  remainder (DIVISOR_W), held until the next result
//   div_zero_o   divisor was zero, held with results
module seq_div #(
  parameter int unsigned DIVIDEND_W = 56,
  parameter int unsigned DIVISOR_W  = 28
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o,
  output logic                  div_zero_o
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
  localparam int unsigned REM_W = DIVISOR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dsh_q, dsh_d;     // dividend shifter, collects quotient bits at LSB
  logic [DIVISOR_W-1:0]  rem_q, rem_d;     // partial remainder (always < divisor)
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic                  dz_q, dz_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
  logic                  dzo_q, dzo_d;

  logic [DIVIDEND_W-1:0] dvd_mag_c;
  logic [DIVISOR_W-1:0]  dvs_mag_c;
  logic [REM_W-1:0]      r_sh_c;
  logic [REM_W-1:0]      r_diff_c;
  logic                  r_ge_c;
  logic [DIVIDEND_W-1:0] fin_quo_c;
  logic [DIVISOR_W-1:0]  fin_rmd_c;

`ifdef SEQ_DIV_SIGNED_EN
  localparam logic [DIVIDEND_W-1:0] QMAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};

  logic neg_q_q, neg_q_d;   // quotient must be negated
  logic neg_r_q, neg_r_d;   // dividend was negative: remainder sign, div-zero sign

  // Operand magnitudes; the most-negative values still fit unsigned.
  always_comb begin
    dvd_mag_c = dividend_i[DIVIDEND_W-1] ? -dividend_i : dividend_i;
    dvs_mag_c = divisor_i[DIVISOR_W-1]   ? -divisor_i  : divisor_i;
  end

  // Sign fix-up of the unsigned core result.
  always_comb begin
    fin_quo_c = dsh_q;
    fin_rmd_c = rem_q;
    if (dz_q) begin
      fin_quo_c = neg_r_q ? -QMAX : QMAX;
    end else begin
      // Positive quotient with MSB set only arises from min / -1: saturate.
      if (!neg_q_q && dsh_q[DIVIDEND_W-1]) fin_quo_c = QMAX;
      else if (neg_q_q)                    fin_quo_c = -dsh_q;
      if (neg_r_q)                         fin_rmd_c = -rem_q;
    end
  end
`else
  always_comb begin
    dvd_mag_c = dividend_i;
    dvs_mag_c = divisor_i;
  end

  always_comb begin
    fin_quo_c = dz_q ? {DIVIDEND_W{1'b1}} : dsh_q;
    fin_rmd_c = rem_q;
  end
`endif

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    r_sh_c   = {rem_q, dsh_q[DIVIDEND_W-1]};
    r_diff_c = r_sh_c - {1'b0, dvs_q};
    r_ge_c   = (r_sh_c >= {1'b0, dvs_q});
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dsh_d   = dsh_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dzo_d   = dzo_q;
`ifdef SEQ_DIV_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          dsh_d  = dvd_mag_c;
          dvs_d  = dvs_mag_c;
          rem_d  = '0;
`ifdef SEQ_DIV_SIGNED_EN
          neg_q_d = dividend_i[DIVIDEND_W-1] ^ divisor_i[DIVISOR_W-1];
          neg_r_d = dividend_i[DIVIDEND_W-1];
`endif
          if (divisor_i == '0) begin
            // Remainder register carries the raw low dividend bits for div-zero.
            dz_d    = 1'b1;
            rem_d   = dividend_i[DIVISOR_W-1:0];
            state_d = S_DONE;
          end else begin
            dz_d    = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        busy_d = 1'b1;
        dsh_d  = {dsh_q[DIVIDEND_W-2:0], r_ge_c};
        rem_d  = r_ge_c ? DIVISOR_W'(r_diff_c) : DIVISOR_W'(r_sh_c);
        cnt_d  = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(DIVIDEND_W - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        quo_d   = fin_quo_c;
        rmd_d   = fin_rmd_c;
        dzo_d   = dz_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dsh_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dzo_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dsh_q   <= dsh_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dzo_q   <= dzo_d;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rmd_q;
  assign div_zero_o  = dzo_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div (default widths 56/28).
// Expected results are queued when an operation is issued and compared
// when done_o pulses; latency and busy are checked by the driver.
module tb_seq_div;

  localparam int unsigned DW = 56;
  localparam int unsigned VW = 28;
  localparam int unsigned LAT = DW + 1;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
  } exp_t;

  logic          clk_i;
  logic          rst_i;
  logic          start_i;
  logic [DW-1:0] dividend_i;
  logic [VW-1:0] divisor_i;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] quotient_o;
  logic [VW-1:0] remainder_o;
  logic          div_zero_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  seq_div #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
`ifdef SEQ_DIV_SIGNED_EN
    logic [DW-1:0] qmax;
    longint sa, sb, sq, sr, minv;
    qmax = {1'b0, {(DW-1){1'b1}}};
    minv = -(64'sd1 <<< (DW - 1));
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    if (b == '0) begin
      e.dz = 1'b1;
      e.r  = a[VW-1:0];
      e.q  = (sa >= 0) ? qmax : -qmax;
    end else if (sa == minv && sb == -64'sd1) begin
      e.q = qmax;
      e.r = '0;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      e.q = sq[DW-1:0];
      e.r = sr[VW-1:0];
    end
`else
    logic [DW-1:0] rr;
    e.dz = 1'b0;
    if (b == '0) begin
      e.dz = 1'b1;
      e.q  = '1;
      e.r  = a[VW-1:0];
    end else begin
      e.q = a / DW'(b);
      rr  = a % DW'(b);
      e.r = rr[VW-1:0];
    end
`endif
    return e;
  endfunction

  // Scoreboard: compare every done pulse against the oldest expectation.
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (done_o) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'(done_o), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("quotient",  64'(quotient_o),  64'(e.q));
        check_eq("remainder", 64'(remainder_o), 64'(e.r));
        check_eq("div_zero",  64'(div_zero_o),  64'(e.dz));
      end
    end
  end

  // Wait (bounded) for done; returns negedges elapsed since the accept edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, input int exp_lat);
    int lat;
    @(negedge clk_i);
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    sb_q.push_back(model(a, b));
    @(negedge clk_i);
    start_i = 1'b0;
    check_eq("busy_after_accept", 64'(busy_o), 64'd1);
    wait_done(lat);
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("busy_at_done", 64'(busy_o), 64'd1);
  endtask

  initial begin : main
    int lat;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    rst_i      = 1'b1;
    start_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_done", 64'(done_o), 64'd0);
    check_eq("rst_quo",  64'(quotient_o), 64'd0);
    check_eq("rst_rem",  64'(remainder_o), 64'd0);
    check_eq("rst_dz",   64'(div_zero_o), 64'd0);
    rst_i = 1'b0;

    // Directed basics and boundaries.
    issue(DW'(100), VW'(7), LAT);
    issue({DW{1'b1}}, {VW{1'b1}}, LAT);
    issue(DW'(5), VW'(9), LAT);
    issue(DW'(0), VW'(13), LAT);
    issue(DW'(1234), VW'(0), 1);
    @(negedge clk_i);
    check_eq("busy_idle_after_dz", 64'(busy_o), 64'd0);

    // start held high: mid-CALC requests ignored, next accept after done.
    @(negedge clk_i);
    start_i    = 1'b1;
    dividend_i = DW'(100);
    divisor_i  = VW'(7);
    sb_q.push_back(model(DW'(100), VW'(7)));
    @(negedge clk_i);
    dividend_i = DW'(81);
    divisor_i  = VW'(9);
    sb_q.push_back(model(DW'(81), VW'(9)));
    wait_done(lat);
    check_eq("held_start_lat1", 64'(lat), 64'(LAT));
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(lat);
    check_eq("held_start_lat2", 64'(lat), 64'(LAT));

    // Reset in the middle of CALC: op discarded, outputs cleared.
    @(negedge clk_i);
    start_i    = 1'b1;
    dividend_i = DW'(200);
    divisor_i  = VW'(3);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (19) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_eq("midrst_busy", 64'(busy_o), 64'd0);
    check_eq("midrst_done", 64'(done_o), 64'd0);
    check_eq("midrst_quo",  64'(quotient_o), 64'd0);
    check_eq("midrst_rem",  64'(remainder_o), 64'd0);
    check_eq("midrst_dz",   64'(div_zero_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (70) @(negedge clk_i);
    issue(DW'(50), VW'(5), LAT);

`ifdef SEQ_DIV_SIGNED_EN
    issue(DW'(-64'sd100), VW'(7), LAT);
    issue(DW'(100), VW'(-64'sd7), LAT);
    issue(DW'(-64'sd100), VW'(-64'sd7), LAT);
    issue({1'b1, {(DW-1){1'b0}}}, {VW{1'b1}}, LAT);
    issue(DW'(-64'sd77), VW'(0), 1);
`endif

    // Random operands, mixing wide, small-divisor and dividend<divisor cases.
    for (int i = 0; i < 30; i++) begin
      a = DW'({$urandom(), $urandom()});
      b = VW'($urandom());
      if (i % 3 == 1) b = VW'($urandom_range(1, 100));
      if (i % 5 == 2) a = DW'($urandom_range(0, 1000));
      issue(a, b, (b == '0) ? 1 : LAT);
    end

    repeat (3) @(negedge clk_i);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
